lvt_hash_req_frontend: RTL and testbench

- Request front-end that sits directly upstream of the LVT multiported hash table.
- Accepts per-port key/value read and write requests over valid/ready handshakes, buffers them in per-port 2-entry FIFOs, and hashes each key to a table index.
- Resolves same-index hazards between ports in the same cycle.
- Drives the table's packed wen/ren/addr/write_data inputs from registers, one request per port per cycle.

---
 rtl/lvt_hash_req_frontend.sv | 180 ++++++++++++++++++
 tb/tb_lvt_hash_req_frontend.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lvt_hash_req_frontend.sv
// Request front-end for the LVT multiported hash table: per-port 2-deep FIFOs,
// XOR-fold key hashing, same-index hazard arbitration and registered table drive.
module lvt_hash_req_frontend #(
    parameter int P           = 2,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 16,
    parameter int INDEX_WIDTH = 8,
    parameter int DATA_WIDTH  = KEY_WIDTH + VALUE_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [P-1:0]             req_valid,
    output logic [P-1:0]             req_ready,
    input  logic [P-1:0]             req_we,
    input  logic [P*KEY_WIDTH-1:0]   req_key,
    input  logic [P*VALUE_WIDTH-1:0] req_value,
    output logic [P-1:0]             wen,
    output logic [P-1:0]             ren,
    output logic [P*INDEX_WIDTH-1:0] addr,
    output logic [P*DATA_WIDTH-1:0]  write_data,
    output logic [15:0]              conflict_stalls
);

    localparam int NSLICE = (KEY_WIDTH + INDEX_WIDTH - 1) / INDEX_WIDTH;
    localparam int PADW   = NSLICE * INDEX_WIDTH;
    localparam int EW     = 1 + KEY_WIDTH + VALUE_WIDTH;
    localparam int PW     = (P > 1) ? $clog2(P) : 1;

    logic [P-1:0]             w_cand;
    logic [P-1:0]             w_head_we;
    logic [P-1:0]             w_issue;
    logic [P-1:0]             w_lose;
    logic [P-1:0]             w_win;
    logic [P-1:0]             w_conflict;
    logic [P-1:0]             w_beaten;
    logic [P-1:0]             w_shared;
    logic [P-1:0]             w_grp_write;
    logic [KEY_WIDTH-1:0]     w_head_key [P];
    logic [VALUE_WIDTH-1:0]   w_head_val [P];
    logic [INDEX_WIDTH-1:0]   w_index    [P];

    logic [PW-1:0]            r_rr_ptr;
    logic [PW-1:0]            w_rr_next;
    logic [16:0]              w_lose_cnt;
    logic [16:0]              w_stall_sum;
    logic [15:0]              r_stalls;
    logic [P-1:0]             r_wen;
    logic [P-1:0]             r_ren;
    logic [P*INDEX_WIDTH-1:0] r_addr;
    logic [P*DATA_WIDTH-1:0]  r_wdata;

    // Distance of a port from the round-robin pointer; smaller wins.
    function automatic int prio(input int port, input logic [PW-1:0] rr);
        return (port + P - int'(rr)) % P;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_port
            logic [EW-1:0]          r_mem [2];
            logic                   r_wr_ptr;
            logic                   r_rd_ptr;
            logic [1:0]             r_count;
            logic                   w_push;
            logic [EW-1:0]          w_head;
            logic [PADW-1:0]        w_key_pad;
            logic [INDEX_WIDTH-1:0] w_idx;

            assign req_ready[gi] = (r_count < 2'd2);
            assign w_push        = req_valid[gi] & req_ready[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wr_ptr <= 1'b0;
                    r_rd_ptr <= 1'b0;
                    r_count  <= 2'd0;
                end else begin
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= {req_we[gi],
                                            req_key[gi*KEY_WIDTH +: KEY_WIDTH],
                                            req_value[gi*VALUE_WIDTH +: VALUE_WIDTH]};
                        r_wr_ptr <= ~r_wr_ptr;
                    end
                    if (w_issue[gi]) begin
                        r_rd_ptr <= ~r_rd_ptr;
                    end
                    r_count <= r_count + {1'b0, w_push} - {1'b0, w_issue[gi]};
                end
            end

            assign w_head          = r_mem[r_rd_ptr];
            assign w_cand[gi]      = (r_count != 2'd0);
            assign w_head_we[gi]   = w_head[EW-1];
            assign w_head_key[gi]  = w_head[VALUE_WIDTH +: KEY_WIDTH];
            assign w_head_val[gi]  = w_head[VALUE_WIDTH-1:0];
            assign w_key_pad       = PADW'(w_head_key[gi]);

            // XOR-fold of the zero-padded key into one index-sized slice.
            always_comb begin
                w_idx = '0;
                for (int s = 0; s < NSLICE; s++) begin
                    w_idx = w_idx ^ w_key_pad[s*INDEX_WIDTH +: INDEX_WIDTH];
                end
            end
            assign w_index[gi] = w_idx;
        end
    endgenerate

    // A group is every candidate sharing an index; it is a hazard only if it holds a write.
    always_comb begin
        w_beaten    = '0;
        w_shared    = '0;
        w_grp_write = w_head_we;
        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < P; j++) begin
                if (j != i && w_cand[j] && (w_index[j] == w_index[i])) begin
                    w_shared[i] = 1'b1;
                    if (w_head_we[j]) begin
                        w_grp_write[i] = 1'b1;
                    end
                    if (prio(j, r_rr_ptr) < prio(i, r_rr_ptr)) begin
                        w_beaten[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_conflict = w_cand & w_shared & w_grp_write;
    assign w_lose     = w_conflict & w_beaten;
    assign w_win      = w_conflict & ~w_beaten;
    assign w_issue    = w_cand & ~w_lose;

    // Descending scan so the lowest-numbered winner sets the pointer.
    always_comb begin
        w_rr_next = r_rr_ptr;
        for (int i = P - 1; i >= 0; i--) begin
            if (w_win[i]) begin
                w_rr_next = PW'((i + 1) % P);
            end
        end
    end

    always_comb begin
        w_lose_cnt = '0;
        for (int i = 0; i < P; i++) begin
            w_lose_cnt = w_lose_cnt + 17'(w_lose[i]);
        end
    end
    assign w_stall_sum = {1'b0, r_stalls} + w_lose_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wen    <= '0;
            r_ren    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_stalls <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_wen <= w_issue & w_head_we;
            r_ren <= w_issue & ~w_head_we;
            for (int i = 0; i < P; i++) begin
                if (w_issue[i]) begin
                    r_addr[i*INDEX_WIDTH +: INDEX_WIDTH] <= w_index[i];
                    r_wdata[i*DATA_WIDTH +: DATA_WIDTH]  <= DATA_WIDTH'({w_head_key[i], w_head_val[i]});
                end
            end
            r_stalls <= (w_stall_sum > 17'h0FFFF) ? 16'hFFFF : w_stall_sum[15:0];
            r_rr_ptr <= w_rr_next;
        end
    end

    assign wen             = r_wen;
    assign ren             = r_ren;
    assign addr            = r_addr;
    assign write_data      = r_wdata;
    assign conflict_stalls = r_stalls;

endmodule

// File: tb/tb_lvt_hash_req_frontend.sv
// Directed bench for lvt_hash_req_frontend (P=2, 16-bit key/value, 8-bit index).
module tb_lvt_hash_req_frontend;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [31:0] req_key;
    logic [31:0] req_value;
    logic [1:0]  wen;
    logic [1:0]  ren;
    logic [15:0] addr;
    logic [63:0] write_data;
    logic [15:0] conflict_stalls;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    lvt_hash_req_frontend #(
        .P(2), .KEY_WIDTH(16), .VALUE_WIDTH(16), .INDEX_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_key(req_key),
        .req_value(req_value),
        .wen(wen),
        .ren(ren),
        .addr(addr),
        .write_data(write_data),
        .conflict_stalls(conflict_stalls)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [15:0] k0, input logic [15:0] k1,
                         input logic [15:0] v0, input logic [15:0] v1);
        req_valid = v;
        req_we    = we;
        req_key   = {k1, k0};
        req_value = {v1, v0};
        $display("txn: valid=%b we=%b key0=%h key1=%h val0=%h val1=%h", v, we, k0, k1, v0, v1);
    endtask

    task automatic idle();
        req_valid = 2'b00;
    endtask

    initial begin
        int acc0, acc1, iss0, iss1, drop_acc0;
        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_key   = '0;
        req_value = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_eq("rst_wen", wen, 2'b00);
        chk_eq("rst_ren", ren, 2'b00);
        chk_eq("rst_addr", addr, 16'h0);
        chk_eq("rst_wdata", write_data, 64'h0);
        chk_eq("rst_stalls", conflict_stalls, 16'h0);
        chk_eq("rst_ready", req_ready, 2'b11);

        // Single read: 0x12^0x34 = 0x26, visible two cycles after valid.
        drive(2'b01, 2'b00, 16'h1234, 16'h0, 16'h0, 16'h0);
        @(negedge clk); idle();
        chk_eq("rd_early_ren", ren, 2'b00);
        chk_eq("rd_ready", req_ready, 2'b11);
        @(negedge clk);
        chk_eq("rd_ren", ren, 2'b01);
        chk_eq("rd_wen", wen, 2'b00);
        chk_eq("rd_addr0", addr[7:0], 8'h26);
        @(negedge clk);
        chk_eq("rd_pulse_end", ren, 2'b00);

        // Parallel write/read on different indexes.
        drive(2'b11, 2'b01, 16'h1234, 16'h0001, 16'hBEEF, 16'h0);
        @(negedge clk); idle();
        @(negedge clk);
        chk_eq("par_wen", wen, 2'b01);
        chk_eq("par_ren", ren, 2'b10);
        chk_eq("par_wdata0", write_data[31:0], 32'h1234BEEF);
        chk_eq("par_addr1", addr[15:8], 8'h01);
        chk_eq("par_stalls", conflict_stalls, 16'h0);

        // Write-write conflict on index 0x26, rr_ptr=0: port0 first.
        drive(2'b11, 2'b11, 16'h1234, 16'h3412, 16'h1111, 16'h2222);
        @(negedge clk); idle();
        @(negedge clk);
        chk_eq("cf1_wen", wen, 2'b01);
        chk_eq("cf1_addr0", addr[7:0], 8'h26);
        chk_eq("cf1_wdata0", write_data[31:0], 32'h12341111);
        chk_eq("cf1_stalls", conflict_stalls, 16'd1);
        @(negedge clk);
        chk_eq("cf1b_wen", wen, 2'b10);
        chk_eq("cf1b_wdata1", write_data[63:32], 32'h34122222);
        chk_eq("cf1b_stalls", conflict_stalls, 16'd1);
        // Same pair again: rr_ptr is now 1, so port1 goes first.
        drive(2'b11, 2'b11, 16'h1234, 16'h3412, 16'h3333, 16'h4444);
        @(negedge clk); idle();
        chk_eq("cf2_gap_wen", wen, 2'b00);
        @(negedge clk);
        chk_eq("cf2_wen", wen, 2'b10);
        chk_eq("cf2_wdata1", write_data[63:32], 32'h34124444);
        chk_eq("cf2_stalls", conflict_stalls, 16'd2);
        @(negedge clk);
        chk_eq("cf2b_wen", wen, 2'b01);
        chk_eq("cf2b_wdata0", write_data[31:0], 32'h12343333);

        // Read-read on the same index issues together without a stall.
        drive(2'b11, 2'b00, 16'h1234, 16'h1234, 16'h0, 16'h0);
        @(negedge clk); idle();
        @(negedge clk);
        chk_eq("rr_ren", ren, 2'b11);
        chk_eq("rr_wen", wen, 2'b00);
        chk_eq("rr_addr", addr, 16'h2626);
        chk_eq("rr_stalls", conflict_stalls, 16'd2);

        // Prime rr_ptr to 1 with one conflict on index 0x55 won by port0.
        drive(2'b11, 2'b11, 16'h0055, 16'h5500, 16'h0, 16'h0);
        @(negedge clk); idle();
        @(negedge clk);
        chk_eq("pr_wen", wen, 2'b01);
        chk_eq("pr_addr", addr[7:0], 8'h55);
        chk_eq("pr_stalls", conflict_stalls, 16'd3);
        @(negedge clk);
        chk_eq("pr_b_wen", wen, 2'b10);

        // Backpressure: both ports stream conflicting writes; values tag accept order.
        acc0 = 0; acc1 = 0; iss0 = 0; iss1 = 0; drop_acc0 = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (wen[0]) begin
                chk_eq("bp_p0_order", write_data[15:0], 16'(iss0));
                iss0++;
            end
            if (wen[1]) begin
                chk_eq("bp_p1_order", write_data[47:32], 16'(iss1));
                iss1++;
            end
            if (c < 8) begin
                if (!req_ready[0] && drop_acc0 < 0) drop_acc0 = acc0;
                drive(2'b11, 2'b11, 16'h1234, 16'h3412, 16'(acc0), 16'(acc1));
                if (req_ready[0]) acc0++;
                if (req_ready[1]) acc1++;
            end else begin
                idle();
            end
        end
        chk_eq("bp_drop_after", 64'(drop_acc0), 64'd2);
        chk_eq("bp_p0_count", 64'(iss0), 64'(acc0));
        chk_eq("bp_p1_count", 64'(iss1), 64'(acc1));

        // Reset while both FIFOs hold requests.
        drive(2'b11, 2'b11, 16'h1234, 16'h3412, 16'hAAAA, 16'hBBBB);
        @(negedge clk);
        drive(2'b11, 2'b11, 16'h1234, 16'h3412, 16'hCCCC, 16'hDDDD);
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_eq("mr_wen", wen, 2'b00);
        chk_eq("mr_ren", ren, 2'b00);
        chk_eq("mr_ready", req_ready, 2'b11);
        chk_eq("mr_stalls", conflict_stalls, 16'h0);
        @(negedge clk);
        chk_eq("mr_after_wen", wen, 2'b00);
        chk_eq("mr_after_ren", ren, 2'b00);
        drive(2'b01, 2'b00, 16'h00AB, 16'h0, 16'h0, 16'h0);
        @(negedge clk); idle();
        chk_eq("mr_lat_early", ren, 2'b00);
        @(negedge clk);
        chk_eq("mr_lat_ren", ren, 2'b01);
        chk_eq("mr_lat_addr", addr[7:0], 8'hAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
